// File: rtl/mux4_rr_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
// Grant selection scans from the requester after the last winner.
package mux_sched_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } sched_state_t;

  // First set request scanning last+1, last+2, last+3, last (mod 4)
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NREQ-1:0]  req,
    input logic [IDX_W-1:0] last
  );
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] idx;
    logic             hit;
    g   = last;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + IDX_W'(k);
      if (!hit && req[idx]) begin
        g   = idx;
        hit = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mux4_rr_sched_if.sv
// Requester / downstream bundle of the round-robin scheduler.
// slave is the scheduler's view, master the environment's view.
interface mux4_rr_sched_if
  import mux_sched_pkg::*;
#(
  parameter int DW = 2
);

  logic [NREQ-1:0]  req;
  logic [DW-1:0]    d0;
  logic [DW-1:0]    d1;
  logic [DW-1:0]    d2;
  logic [DW-1:0]    d3;
  logic             out_ready;
  logic [IDX_W-1:0] sel;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [IDX_W-1:0] out_src;
  logic [NREQ-1:0]  ack;
  logic             busy;

  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output sel, out_valid, out_data, out_src, ack, busy
  );

  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  sel, out_valid, out_data, out_src, ack, busy
  );

endinterface

// File: rtl/mux4_1.sv
// Purely combinational 4:1 datapath multiplexer.
// Select is owned by the scheduler in front of it.
module mux4_1 #(
  parameter int DW = 2
) (
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic [1:0]    sel,
  output logic [DW-1:0] mux_out
);

  // Route the selected requester word
  always_comb begin
    mux_out = d0;
    unique case (sel)
      2'd0: mux_out = d0;
      2'd1: mux_out = d1;
      2'd2: mux_out = d2;
      2'd3: mux_out = d3;
      default: mux_out = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler owning the mux4_1 select.
// Captures the granted word and hands it downstream valid/ready.
module mux4_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int DW = 2
) (
  input logic             clk,
  input logic             rst_n,
  mux4_rr_sched_if.slave  bus
);

  sched_state_t     state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] sel_q;
  logic             vld_q;
  logic [DW-1:0]    data_q;
  logic [IDX_W-1:0] src_q;
  logic [NREQ-1:0]  ack_q;
  logic             busy_q;
  logic [DW-1:0]    mux_out;

  mux4_1 #(
    .DW(DW)
  ) u_mux (
    .d0      (bus.d0),
    .d1      (bus.d1),
    .d2      (bus.d2),
    .d3      (bus.d3),
    .sel     (sel_q),
    .mux_out (mux_out)
  );

  // Arbitrate in IDLE, capture in LOAD, wait for handshake in HOLD
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= IDX_W'(NREQ - 1);
      sel_q  <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      src_q  <= '0;
      ack_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            sel_q  <= rr_pick(bus.req, last);
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.req[sel_q]) begin
            data_q <= mux_out;
            src_q  <= sel_q;
            vld_q  <= 1'b1;
            ack_q  <= NREQ'(1) << sel_q;
            state  <= HOLD;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        HOLD: begin
          if (vld_q && bus.out_ready) begin
            vld_q  <= 1'b0;
            last   <= src_q;
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Bench for mux4_rr_sched: directed scenarios then random traffic,
// all outputs compared each cycle against a behavioural model.
module tb_mux4_rr_sched;
  import mux_sched_pkg::*;

  localparam int DW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux4_rr_sched_if #(.DW(DW)) bus ();

  mux4_rr_sched #(
    .DW(DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] td[4];
  logic [3:0]    treq = '0;
  logic          trdy = 1'b0;

  // model: phase 0 waiting, 1 word being fetched, 2 word on output
  int m_ph, m_last, m_sel, m_src, m_vld, m_data, m_ack;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.req       = treq;
    bus.d0        = td[0];
    bus.d1        = td[1];
    bus.d2        = td[2];
    bus.d3        = td[3];
    bus.out_ready = trdy;
  endtask

  task automatic model_step();
    int bd, best;
    if (!rst_n) begin
      m_ph = 0; m_last = 3; m_sel = 0; m_src = 0;
      m_vld = 0; m_data = 0; m_ack = 0;
    end else begin
      m_ack = 0;
      case (m_ph)
        0: if (treq != 0) begin
          bd = 4; best = 0;
          for (int i = 0; i < 4; i++)
            if (treq[i] && ((i + 7 - m_last) % 4) < bd) begin
              bd = (i + 7 - m_last) % 4;
              best = i;
            end
          m_sel = best;
          m_ph = 1;
        end
        1: if (treq[m_sel]) begin
          m_data = int'(td[m_sel]);
          m_src = m_sel;
          m_vld = 1;
          m_ack = 1 << m_sel;
          m_ph = 2;
        end else begin
          m_ph = 0;
        end
        default: if (trdy) begin
          m_vld = 0;
          m_last = m_src;
          m_ph = 0;
        end
      endcase
    end
  endtask

  task automatic check_all();
    chk("sel", 32'(bus.sel), m_sel);
    chk("out_valid", 32'(bus.out_valid), m_vld);
    chk("out_data", 32'(bus.out_data), m_data);
    chk("out_src", 32'(bus.out_src), m_src);
    chk("ack", 32'(bus.ack), m_ack);
    chk("busy", 32'(bus.busy), (m_ph != 0) ? 1 : 0);
  endtask

  task automatic cyc();
    drive();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) td[i] = '0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_sel", 32'(bus.sel), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // single request on 2
    treq = 4'b0100; td[2] = 2'd2; trdy = 1'b1;
    cyc();
    chk("single_sel", 32'(bus.sel), 2);
    cyc();
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_data", 32'(bus.out_data), 2);
    chk("single_src", 32'(bus.out_src), 2);
    chk("single_ack", 32'(bus.ack), 4'b0100);
    treq = '0;
    cyc();
    chk("single_ack_off", 32'(bus.ack), 0);
    chk("single_idle", 32'(bus.busy), 0);

    // all four back to back from reset priority
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) td[i] = DW'(i);
    treq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      cyc();
      chk("b2b_src", 32'(bus.out_src), k % 4);
      chk("b2b_data", 32'(bus.out_data), k % 4);
      cyc();
    end
    treq = '0;
    cyc();

    // backpressure on requester 1
    treq = 4'b0010; td[1] = 2'd1; trdy = 1'b0;
    cyc();
    cyc();
    chk("bp_ack", 32'(bus.ack), 4'b0010);
    treq = '0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_data", 32'(bus.out_data), 1);
      chk("bp_src", 32'(bus.out_src), 1);
      chk("bp_ack_once", 32'(bus.ack), 0);
    end
    trdy = 1'b1;
    cyc();
    chk("bp_done", 32'(bus.busy), 0);

    // withdraw during LOAD, last stays at 1
    treq = 4'b1000;
    cyc();
    chk("wd_sel", 32'(bus.sel), 3);
    treq = '0;
    cyc();
    chk("wd_ack", 32'(bus.ack), 0);
    chk("wd_valid", 32'(bus.out_valid), 0);
    chk("wd_busy", 32'(bus.busy), 0);
    treq = 4'b1111;
    cyc();
    chk("wd_last", 32'(bus.sel), 2);
    cyc();
    treq = '0;
    cyc();

    // fairness after a grant to 2
    treq = 4'b1001;
    cyc();
    cyc();
    chk("fair_first", 32'(bus.out_src), 3);
    cyc();
    cyc();
    cyc();
    chk("fair_second", 32'(bus.out_src), 0);
    cyc();
    treq = '0;
    cyc();

    // reset while holding a word
    treq = 4'b0100; trdy = 1'b0;
    cyc();
    cyc();
    chk("rh_valid_pre", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rh_valid", 32'(bus.out_valid), 0);
    chk("rh_data", 32'(bus.out_data), 0);
    chk("rh_src", 32'(bus.out_src), 0);
    chk("rh_busy", 32'(bus.busy), 0);
    treq = 4'b1111; trdy = 1'b1;
    cyc();
    chk("rh_first", 32'(bus.sel), 0);

    // random traffic; requesters hold until acked
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ack[i]) begin
          treq[i] = 1'b0;
        end else if (!treq[i] && ($urandom % 3 == 0)) begin
          treq[i] = 1'b1;
          td[i] = DW'($urandom);
        end
      end
      trdy  = 1'($urandom % 2);
      rst_n = ($urandom % 200 == 0) ? 1'b0 : 1'b1;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mux4_rr_sched.md
# mux4_rr_sched

Round-robin scheduler that shares the 4:1 datapath multiplexer (`mux4_1`) among four requesters. It owns the mux `sel` input and grants one requester at a time. It captures the selected word into an output register and presents it downstream with a valid/ready handshake. It sits directly in front of `mux4_1` and is the only driver of that mux's select.

## Interface

Parameters:
- `DW`, default 2: data width of each requester word and of `out_data`. Matches the `mux4_1` data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  4  per-requester request; `req[i]` is held with `d<i>` stable until `ack[i]`.
- `d0`..`d3`  in  DW each  requester data, routed into `mux4_1`.
- `out_ready`  in  1  downstream ready.
- `sel`  out  2  registered select driving `mux4_1.sel`.
- `out_valid`  out  1  output word valid.
- `out_data`  out  DW  captured word.
- `out_src`  out  2  index of the requester that produced `out_data`.
- `ack`  out  4  one-hot, one-cycle pulse; the requester's word has been captured.
- `busy`  out  1  high when the state is not IDLE.

## Operation

- The FSM has three states: IDLE, LOAD and HOLD.
- `last` (2 b) holds the most recently completed requester. Its reset value is 3, so requester 0 has first priority.
- IDLE:
  - If `req != 0`, the grant `g` is the first set bit scanning `last+1, last+2, last+3, last` (mod 4).
  - `sel <= g`, then go to LOAD.
  - If `req == 0`, stay in IDLE; `sel` holds its value.
- LOAD:
  - If `req[sel]` is high: `out_data <= mux4_1.mux_out`, `out_src <= sel`, `out_valid <= 1`, `ack[sel] <= 1`, then go to HOLD.
  - If `req[sel]` is low (requester withdrew): go to IDLE with no ack and no output, and `last` is unchanged.
- HOLD:
  - `ack` returns to 0 after its single cycle.
  - `out_data`, `out_src` and `out_valid` stay stable while `out_ready` is low. Wait is unbounded.
  - On `out_valid && out_ready`: `out_valid <= 0`, `last <= out_src`, go to IDLE.
- Requests arriving during LOAD or HOLD are only evaluated in the next IDLE cycle.
- A requester never receives two consecutive grants while another requester is asserting.
- `req` changes on non-granted lines never affect the transfer in flight.

## Timing

- Reset values: `sel` = 0, `out_valid` = 0, `out_data` = 0, `out_src` = 0, `ack` = 0, `busy` = 0, state = IDLE, `last` = 3.
- Reset applies at any edge with `rst_n` low, including mid-LOAD or mid-HOLD. The in-flight word is discarded and no ack is issued if reset hits during LOAD.
- Latency: `req` sampled at edge E0 gives `sel` valid after E0, and `out_valid` and `ack` high after E1.
- With `out_ready` = 1, the handshake completes at E2 and the next arbitration happens at E3. Maximum throughput is one word per 3 cycles.
- `ack[i]` is high for exactly one cycle, coincident with the first cycle of `out_valid`.
- `mux4_1` is purely combinational. The data sampled in LOAD is from the `sel` registered one edge earlier.

## Structure

- Package `mux_sched_pkg` holds:
  - `localparam NREQ = 4` and `localparam IDX_W = 2`.
  - `typedef enum logic [1:0] {IDLE, LOAD, HOLD} sched_state_t`.
  - function `rr_pick(req, last)`, which returns the grant index.
- Sub-module: one instance of the existing `mux4_1` for the datapath. The scheduler contains no data mux of its own.

## Test plan

- **Single request.** Reset, then `req = 4'b0100`, `d2 = 2`, `out_ready = 1`. Expect:
  - `sel = 2` one cycle later.
  - Next cycle: `out_valid = 1`, `out_data = 2`, `out_src = 2`, `ack = 4'b0100` for one cycle.
  - Return to IDLE; `last = 2`.
- **All four, back to back.** `req = 4'b1111`, `d0..d3 = 0,1,2,3`, `out_ready = 1`, each line held until its ack then re-raised. Expect `out_src` sequence 0,1,2,3,0 with `out_data` equal to `out_src`, one word every 3 cycles.
- **Backpressure.** Single request on 1, `out_ready = 0` for 5 cycles, then 1. Expect:
  - `out_valid`, `out_data = 1` and `out_src = 1` stable for all 6 cycles.
  - `ack[1]` pulses once only.
  - IDLE after the handshake.
- **Withdraw in LOAD.** `req[3]` high for one cycle only. Expect `sel = 3`, LOAD, then IDLE with `ack = 0`, `out_valid = 0` and `last` unchanged.
- **Fairness.** After a completed grant to 2, assert `req = 4'b1001`. Expect the grant order 3 then 0.
- **Reset mid-HOLD.** `rst_n = 0` for one cycle while `out_valid = 1`. Expect all outputs at their reset values on the next cycle, and `last = 3` (a following `req = 4'b1111` grants 0 first).
